i2c_cfg_sequencer: RTL
======================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Walks a table of {reg_addr[15:0], data[7:0]} entries held in an external ROM.
//  Issues one single-byte I2C write per entry through the i2c_dirver request interface.
//  Inserts a fixed write-cycle gap after every transaction, retries failed writes, and times out stalls.
//  Sits between system init logic and i2c_dirver; reports init done or fail plus the failing entry index.
// PARAMETERS
//  ENTRY_NUM      16         number of table entries, 1..256
//  GAP_CYCLES     250_000    clk cycles idle after each transaction (5 ms at 50 MHz EEPROM tWR), >=1
//  MAX_RETRY      3          re-issues allowed per entry after error/timeout, 0..15
//  TIMEOUT_CYCLES 1_000_000  clk cycles in WAIT with no done/error before it is treated as an error
// PORTS
//  clk               in   1   system clock
//  rst_n             in   1   asynchronous active-low reset
//  i_start           in   1   start/restart pulse; ignored while o_busy=1
//  o_busy            out  1   sequence in progress
//  o_init_done       out  1   all entries written; held until next start
//  o_init_fail       out  1   entry exhausted its retries; held until next start
//  o_fail_idx        out  8   index of the failing entry; valid while o_init_fail=1
//  o_rom_idx         out  8   table read address
//  i_rom_data        in   24  {addr[23:8], data[7:0]}; valid 1 cycle after o_rom_idx changes
//  o_iic_addr        out  16  register address to the driver
//  o_iic_wr_data     out  8   write byte to the driver
//  o_iic_wr_byte_num out  6   constant 6'd0 (driver count is N-1, i.e. one byte)
//  o_iic_wr_req      out  1   single-cycle write request pulse
//  o_iic_rd_req      out  1   constant 0
//  i_iic_work_done   in   1   driver done level; high for the whole STOP phase
//  i_iic_error       in   1   driver NACK/error level
// BEHAVIOUR
//  Reset values
//   - All outputs 0; state IDLE; idx=0; retry=0; counters 0.
//  Driver inputs
//   - i_iic_work_done and i_iic_error are registered once.
//   - Only the rising edge of each is acted on, so one transaction yields one event.
//  States
//   - IDLE: i_start=1 -> FETCH. Clears idx, retry, o_init_done and o_init_fail.
//   - FETCH (2 cycles): o_rom_idx=idx. On the 2nd cycle, latch i_rom_data into o_iic_addr/o_iic_wr_data, then -> ISSUE.
//   - ISSUE (1 cycle): o_iic_wr_req=1, timeout counter cleared, -> WAIT.
//   - WAIT:
//     - error edge, or timeout counter reaching TIMEOUT_CYCLES-1, sets err_flag.
//     - done edge clears err_flag.
//     - Either event -> GAP.
//     - Error wins if done and error edges coincide.
//   - GAP: counts GAP_CYCLES cycles, then:
//     - err_flag=1 and retry<MAX_RETRY: retry++, -> ISSUE (same addr/data, no refetch).
//     - err_flag=1 and retry==MAX_RETRY: -> FAIL with o_fail_idx=idx.
//     - err_flag=0 and idx==ENTRY_NUM-1: -> DONE.
//     - err_flag=0 otherwise: idx++, retry=0, -> FETCH.
//   - DONE: o_init_done=1. i_start -> FETCH with a full restart from idx 0 (same clears as IDLE).
//   - FAIL: o_init_fail=1. i_start -> FETCH with a full restart from idx 0 (same clears as IDLE).
//  Outputs and counters
//   - o_busy=1 in FETCH/ISSUE/WAIT/GAP; 0 in IDLE/DONE/FAIL.
//   - o_iic_addr/o_iic_wr_data are held stable from ISSUE until the next FETCH; the driver samples them late.
//   - Gap and timeout counters are 32 bit and saturate-free; they clear on state entry.
//   - idx is 8 bit and never wraps: the last index is ENTRY_NUM-1.
//   - o_init_done and o_init_fail are never high together.
//  Reset mid-operation
//   - Asynchronous return to IDLE within one clk; o_iic_wr_req drops immediately.
//   - The driver is reset by the same rst_n.
// TESTING
//  (bench params: ENTRY_NUM=3, GAP_CYCLES=10, MAX_RETRY=2, TIMEOUT_CYCLES=200; driver BFM)
//  1. ROM {0x0010_A5, 0x0011_5A, 0x0100_FF}, start, BFM acks all
//     -> 3 wr_req pulses with matching addr/data, each >=10 cycles apart;
//     -> o_init_done=1, o_busy=0, exactly 3 requests.
//  2. BFM errors entry 1 once, then acks
//     -> entry 1 requested twice with identical addr/data; o_init_done=1, total 4 requests.
//  3. BFM errors entry 2 always
//     -> 3 requests for entry 2 (1+MAX_RETRY); o_init_fail=1, o_fail_idx=2, o_init_done=0.
//  4. BFM never responds to entry 0
//     -> after 200 cycles in WAIT, retry; after 3 timeouts o_init_fail=1, o_fail_idx=0.
//  5. Done level held 20 cycles, plus i_start pulsed while busy
//     -> exactly one event per transaction; start ignored; sequence unchanged.
//  6. rst_n low during WAIT of entry 1, then start
//     -> outputs 0 at once; after restart the first request is entry 0 (addr 0x0010).

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a ROM table of {reg_addr, data} entries and issues
// one single-byte I2C write per entry, with a write-cycle gap after every
// transaction, bounded retries and a stall timeout.
module i2c_cfg_sequencer #(
   parameter int ENTRY_NUM      = 16,
   parameter int GAP_CYCLES     = 250_000,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_init_done,
   output logic        o_init_fail,
   output logic [7:0]  o_fail_idx,
   output logic [7:0]  o_rom_idx,
   input  logic [23:0] i_rom_data,
   output logic [15:0] o_iic_addr,
   output logic [7:0]  o_iic_wr_data,
   output logic [5:0]  o_iic_wr_byte_num,
   output logic        o_iic_wr_req,
   output logic        o_iic_rd_req,
   input  logic        i_iic_work_done,
   input  logic        i_iic_error
);

   localparam logic [7:0]  LAST_IDX  = 8'(ENTRY_NUM - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5,
      S_FAIL  = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_done_s, r_done_p, r_err_s, r_err_p;
   logic        r_fetch_cnt;
   logic        r_err_flag;
   logic [7:0]  r_idx;
   logic [3:0]  r_retry;
   logic [31:0] r_gap_cnt;
   logic [31:0] r_to_cnt;
   logic        w_done_edge, w_err_edge, w_timeout, w_gap_end;

   // The driver count field is N-1, so zero means one byte; reads are never issued.
   assign o_iic_wr_byte_num = 6'd0;
   assign o_iic_rd_req      = 1'b0;

   assign w_done_edge = r_done_s & ~r_done_p;
   assign w_err_edge  = r_err_s & ~r_err_p;
   assign w_timeout   = (r_to_cnt == TO_LAST);
   assign w_gap_end   = (r_gap_cnt == GAP_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (i_start) begin
               w_next_state = S_FETCH;
            end else begin
               w_next_state = r_state;
            end
         end
         S_FETCH: begin
            if (r_fetch_cnt) begin
               w_next_state = S_ISSUE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_ISSUE: w_next_state = S_WAIT;
         S_WAIT: begin
            if (w_err_edge || w_timeout || w_done_edge) begin
               w_next_state = S_GAP;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_GAP: begin
            if (!w_gap_end) begin
               w_next_state = S_GAP;
            end else if (r_err_flag) begin
               if (r_retry < RETRY_MAX) begin
                  w_next_state = S_ISSUE;
               end else begin
                  w_next_state = S_FAIL;
               end
            end else if (r_idx == LAST_IDX) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Driver status registered once, plus a delayed copy for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_s <= 1'b0;
         r_done_p <= 1'b0;
         r_err_s  <= 1'b0;
         r_err_p  <= 1'b0;
      end else begin
         r_done_s <= i_iic_work_done;
         r_done_p <= r_done_s;
         r_err_s  <= i_iic_error;
         r_err_p  <= r_err_s;
      end
   end

   // Cycle counters for fetch latency, wait timeout and gap; each restarts on state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= 1'b0;
         r_to_cnt    <= 32'd0;
         r_gap_cnt   <= 32'd0;
      end else begin
         r_fetch_cnt <= (r_state == S_FETCH) && (w_next_state == S_FETCH);
         r_to_cnt    <= (r_state == S_WAIT) ? (r_to_cnt + 32'd1) : 32'd0;
         r_gap_cnt   <= (r_state == S_GAP) ? (r_gap_cnt + 32'd1) : 32'd0;
      end
   end

   // Transaction outcome: an error edge or timeout marks the entry for retry,
   // a done edge clears it; error takes priority when both arrive together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_flag <= 1'b0;
      end else if (r_state == S_WAIT) begin
         if (w_err_edge || w_timeout) begin
            r_err_flag <= 1'b1;
         end else if (w_done_edge) begin
            r_err_flag <= 1'b0;
         end
      end
   end

   // Sequence bookkeeping: entry index, retry count, status flags and driver payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= 8'd0;
         r_retry       <= 4'd0;
         o_init_done   <= 1'b0;
         o_init_fail   <= 1'b0;
         o_fail_idx    <= 8'd0;
         o_rom_idx     <= 8'd0;
         o_iic_addr    <= 16'd0;
         o_iic_wr_data <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (i_start) begin
                  r_idx       <= 8'd0;
                  r_retry     <= 4'd0;
                  o_init_done <= 1'b0;
                  o_init_fail <= 1'b0;
                  o_fail_idx  <= 8'd0;
                  o_rom_idx   <= 8'd0;
               end
            end
            S_FETCH: begin
               // ROM data settles one cycle after the index; capture on the second cycle.
               if (r_fetch_cnt) begin
                  o_iic_addr    <= i_rom_data[23:8];
                  o_iic_wr_data <= i_rom_data[7:0];
               end
            end
            S_GAP: begin
               if (w_gap_end) begin
                  if (r_err_flag) begin
                     if (r_retry < RETRY_MAX) begin
                        r_retry <= r_retry + 4'd1;
                     end else begin
                        o_init_fail <= 1'b1;
                        o_fail_idx  <= r_idx;
                     end
                  end else if (r_idx == LAST_IDX) begin
                     o_init_done <= 1'b1;
                  end else begin
                     r_idx     <= r_idx + 8'd1;
                     r_retry   <= 4'd0;
                     o_rom_idx <= r_idx + 8'd1;
                  end
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   // Registered state-derived outputs: busy level and one-cycle write request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_busy       <= 1'b0;
         o_iic_wr_req <= 1'b0;
      end else begin
         o_busy       <= (w_next_state == S_FETCH) || (w_next_state == S_ISSUE) ||
                         (w_next_state == S_WAIT)  || (w_next_state == S_GAP);
         o_iic_wr_req <= (w_next_state == S_ISSUE);
      end
   end

endmodule
